// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_if
//  Purpose  : Instruction-memory read bus between the fetch unit and memory.
//  Revision : 1.0  initial release
// ============================================================================
interface inst_fetch_if;
    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic        if_mem_ack;
    logic [31:0] if_mem_rdata;

    modport master (
        output if_mem_req,
        output if_mem_addr,
        input  if_mem_ack,
        input  if_mem_rdata
    );

    modport slave (
        input  if_mem_req,
        input  if_mem_addr,
        output if_mem_ack,
        output if_mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : Single-outstanding instruction fetch with timeout and branch/jump
//             field decode for the program counter.
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  wire logic        if_clk,
    input  wire logic        if_rst,
    input  wire logic        if_en,
    input  wire logic [31:0] if_pc_in,
    input  wire logic        if_cond,
    inst_fetch_if.master     mem,
    output logic [31:0]      if_inst,
    output logic             if_inst_valid,
    output logic             if_branch,
    output logic             if_jmp,
    output logic             if_link,
    output logic [31:0]      if_offset_addr,
    output logic             if_stall,
    output logic [1:0]       if_err
);

    localparam logic [3:0] c_timeout      = 4'(TIMEOUT_CYCLES);
    localparam logic [5:0] c_op_j         = 6'h02;
    localparam logic [5:0] c_op_jal       = 6'h03;
    localparam logic [5:0] c_op_beq       = 6'h04;
    localparam logic [5:0] c_op_bne       = 6'h05;
    localparam logic [1:0] c_err_none     = 2'b00;
    localparam logic [1:0] c_err_misalign = 2'b01;
    localparam logic [1:0] c_err_timeout  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] w_addr_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  w_cnt_inc;
    logic [1:0]  r_err;
    logic [1:0]  w_err_nxt;
    logic [5:0]  w_opcode;

    assign w_opcode  = r_inst[31:26];
    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge if_clk) begin
        if (if_rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_inst  <= '0;
            r_cnt   <= '0;
            r_err   <= c_err_none;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_inst  <= w_inst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_inst_nxt     = r_inst;
        w_cnt_nxt      = r_cnt;
        w_err_nxt      = c_err_none;
        if_inst_valid  = 1'b0;
        if_branch      = 1'b0;
        if_jmp         = 1'b0;
        if_link        = 1'b0;
        if_offset_addr = '0;

        case (r_state)
            S_IDLE: begin
                if (if_en) begin
                    if (if_pc_in[1:0] == 2'b00) begin
                        w_addr_nxt  = if_pc_in;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_err_nxt = c_err_misalign;
                    end
                end
            end
            S_REQ: begin
                // An ack in the final allowed cycle still completes the fetch.
                if (mem.if_mem_ack) begin
                    w_inst_nxt  = mem.if_mem_rdata;
                    w_state_nxt = S_DECODE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_timeout) begin
                        w_err_nxt   = c_err_timeout;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DECODE: begin
                w_state_nxt   = S_IDLE;
                if_inst_valid = 1'b1;
                case (w_opcode)
                    c_op_beq: begin
                        if_branch      = if_cond;
                        if_offset_addr = {{16{r_inst[15]}}, r_inst[15:0]};
                    end
                    c_op_bne: begin
                        if_branch      = ~if_cond;
                        if_offset_addr = {{16{r_inst[15]}}, r_inst[15:0]};
                    end
                    c_op_j: begin
                        if_jmp         = 1'b1;
                        if_offset_addr = {6'b0, r_inst[25:0]};
                    end
                    c_op_jal: begin
                        if_jmp         = 1'b1;
                        if_link        = 1'b1;
                        if_offset_addr = {6'b0, r_inst[25:0]};
                    end
                    default: begin
                        if_offset_addr = '0;
                    end
                endcase
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem.if_mem_req  = (r_state == S_REQ);
    assign mem.if_mem_addr = r_addr;
    assign if_stall        = (r_state != S_IDLE);
    assign if_err          = r_err;
    assign if_inst         = r_inst;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// Testbench for inst_fetch: directed decode table, hand-written corner cases
// and a randomized run against a cycle-level reference model.
module tb_inst_fetch;

    localparam int TO = 15;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        cond = 1'b0;
    logic [31:0] pc   = '0;
    logic [31:0] inst;
    logic [31:0] off;
    logic        iv, br, jmp, lnk, stall;
    logic [1:0]  err;

    inst_fetch_if bus();

    inst_fetch #(.TIMEOUT_CYCLES(TO)) dut (
        .if_clk        (clk),
        .if_rst        (rst),
        .if_en         (en),
        .if_pc_in      (pc),
        .if_cond       (cond),
        .mem           (bus),
        .if_inst       (inst),
        .if_inst_valid (iv),
        .if_branch     (br),
        .if_jmp        (jmp),
        .if_link       (lnk),
        .if_offset_addr(off),
        .if_stall      (stall),
        .if_err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        br;
        logic        jmp;
        logic        lnk;
        logic [31:0] off;
    } dec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        cond;
        logic        e_br;
        logic        e_jmp;
        logic        e_lnk;
        logic [31:0] e_off;
    } vec_t;

    vec_t tbl[10];

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench settled inside the first REQ cycle.
    task automatic start_fetch(input logic [31:0] a);
        en = 1'b1;
        pc = a;
        cyc();
        en = 1'b0;
        #2;
    endtask

    // Leaves the bench settled inside the DECODE cycle, with cond applied.
    task automatic ack_after(input int waits, input logic [31:0] data, input logic c,
                             output int stalls);
        stalls = 0;
        repeat (waits) begin
            bus.if_mem_ack = 1'b0;
            if (stall) stalls++;
            cyc();
            #2;
        end
        bus.if_mem_ack   = 1'b1;
        bus.if_mem_rdata = data;
        if (stall) stalls++;
        cyc();
        bus.if_mem_ack = 1'b0;
        cond           = c;
        #2;
        if (stall) stalls++;
    endtask

    // Decode rules expressed on the instruction's numeric fields.
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic c);
        dec_t d;
        int   op;
        int   imm;
        d  = '0;
        op = int'(ins >> 26);
        if (op == 4 || op == 5) begin
            imm = int'(ins & 32'h0000FFFF);
            if (imm >= 32768) imm = imm - 65536;
            d.off = 32'(imm);
            d.br  = (op == 4) ? c : !c;
        end else if (op == 2 || op == 3) begin
            d.off = ins & 32'h03FFFFFF;
            d.jmp = 1'b1;
            d.lnk = (op == 3);
        end
        return d;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[31:26] = 6'h02;
            1: r[31:26] = 6'h03;
            2: r[31:26] = 6'h04;
            3: r[31:26] = 6'h05;
            default: r[31:26] = r[31:26];
        endcase
        return r;
    endfunction

    // Reference model state
    logic        m_busy, m_dec;
    int          m_wait;
    logic [31:0] m_addr, m_inst;
    logic [1:0]  m_err;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   s;
        int   ack_pct;
        dec_t d;
        logic [1:0] nerr;

        tbl[0] = '{32'h00000010, 32'h1085FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE};
        tbl[1] = '{32'h00000020, 32'h1085FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE};
        tbl[2] = '{32'h00000024, 32'h14A0000C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000000C};
        tbl[3] = '{32'h00000028, 32'h14A0000C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000000C};
        tbl[4] = '{32'h0000002C, 32'h0C000040, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000040};
        tbl[5] = '{32'h00000030, 32'h08123456, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00123456};
        tbl[6] = '{32'h00000034, 32'h0BFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h03FFFFFF};
        tbl[7] = '{32'h00000038, 32'h20001234, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000};
        tbl[8] = '{32'h8000003C, 32'h10008000, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF8000};
        tbl[9] = '{32'hFFFFFFFC, 32'h10007FFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00007FFF};

        bus.if_mem_ack   = 1'b0;
        bus.if_mem_rdata = '0;
        repeat (3) cyc();
        rst = 1'b0;
        #2;
        chk1 ("rst_mem_req", bus.if_mem_req, 1'b0);
        chk32("rst_addr",    bus.if_mem_addr, 32'h0);
        chk32("rst_inst",    inst, 32'h0);
        chk1 ("rst_valid",   iv, 1'b0);
        chk1 ("rst_branch",  br, 1'b0);
        chk1 ("rst_jmp",     jmp, 1'b0);
        chk1 ("rst_link",    lnk, 1'b0);
        chk32("rst_offset",  off, 32'h0);
        chk1 ("rst_stall",   stall, 1'b0);
        chk32("rst_err",     32'(err), 32'h0);

        // Decode table, minimum-latency fetches
        for (int i = 0; i < 10; i++) begin
            start_fetch(tbl[i].pc);
            chk1 ("tbl_mem_req", bus.if_mem_req, 1'b1);
            chk32("tbl_addr",    bus.if_mem_addr, tbl[i].pc);
            ack_after(0, tbl[i].rdata, tbl[i].cond, s);
            chk1 ("tbl_valid",   iv, 1'b1);
            chk32("tbl_inst",    inst, tbl[i].rdata);
            chk1 ("tbl_branch",  br, tbl[i].e_br);
            chk1 ("tbl_jmp",     jmp, tbl[i].e_jmp);
            chk1 ("tbl_link",    lnk, tbl[i].e_lnk);
            chk32("tbl_offset",  off, tbl[i].e_off);
            cyc();
            #2;
            chk1 ("tbl_valid_drop", iv, 1'b0);
            chk32("tbl_offset_drop", off, 32'h0);
        end

        // jal with three wait cycles: 4 REQ cycles + 1 DECODE
        start_fetch(32'h00000040);
        ack_after(3, 32'h0C000040, 1'b0, s);
        chk32("jal_stall_cycles", 32'(s), 32'd5);
        chk1 ("jal_valid", iv, 1'b1);
        chk1 ("jal_jmp",   jmp, 1'b1);
        chk1 ("jal_link",  lnk, 1'b1);
        chk32("jal_off",   off, 32'h00000040);
        cyc();
        #2;
        chk1 ("jal_stall_drop", stall, 1'b0);

        // Misaligned PC
        en = 1'b1;
        pc = 32'h00000006;
        cyc();
        en = 1'b0;
        #2;
        chk32("mis_err",     32'(err), 32'h1);
        chk1 ("mis_mem_req", bus.if_mem_req, 1'b0);
        chk1 ("mis_stall",   stall, 1'b0);
        cyc();
        #2;
        chk32("mis_err_pulse", 32'(err), 32'h0);
        chk1 ("mis_mem_req2",  bus.if_mem_req, 1'b0);

        // Timeout after exactly TO request cycles
        start_fetch(32'h00000200);
        for (int k = 0; k < TO; k++) begin
            chk1("to_mem_req", bus.if_mem_req, 1'b1);
            bus.if_mem_ack = 1'b0;
            cyc();
            #2;
        end
        chk32("to_err",     32'(err), 32'h2);
        chk1 ("to_mem_req_drop", bus.if_mem_req, 1'b0);
        chk1 ("to_stall",   stall, 1'b0);
        cyc();
        #2;
        chk32("to_err_pulse", 32'(err), 32'h0);

        // Ack in the last allowed cycle wins over timeout
        start_fetch(32'h00000204);
        ack_after(TO - 1, 32'h20000000, 1'b0, s);
        chk32("late_ack_err",   32'(err), 32'h0);
        chk1 ("late_ack_valid", iv, 1'b1);
        cyc();
        #2;
        chk32("late_ack_err2",  32'(err), 32'h0);

        // Reset during REQ, then a stray ack
        start_fetch(32'h00000300);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.if_mem_ack   = 1'b1;
        bus.if_mem_rdata = 32'h0C000001;
        #2;
        chk1 ("rreq_mem_req", bus.if_mem_req, 1'b0);
        chk1 ("rreq_stall",   stall, 1'b0);
        chk32("rreq_addr",    bus.if_mem_addr, 32'h0);
        chk32("rreq_inst",    inst, 32'h0);
        chk32("rreq_err",     32'(err), 32'h0);
        cyc();
        bus.if_mem_ack = 1'b0;
        #2;
        chk1 ("rreq_valid", iv, 1'b0);
        chk32("rreq_inst2", inst, 32'h0);
        chk1 ("rreq_jmp",   jmp, 1'b0);
        chk1 ("rreq_stall2", stall, 1'b0);

        // Ack while idle is ignored
        bus.if_mem_ack   = 1'b1;
        bus.if_mem_rdata = 32'hDEADBEEF;
        cyc();
        bus.if_mem_ack = 1'b0;
        #2;
        chk32("idle_ack_inst",  inst, 32'h0);
        chk1 ("idle_ack_stall", stall, 1'b0);

        // Randomized run against the reference model
        m_busy = 1'b0; m_dec = 1'b0; m_wait = 0;
        m_addr = '0;   m_inst = '0;  m_err = 2'b00;
        ack_pct = 2;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) ack_pct = (ack_pct == 30) ? 2 : 30;
            rst  = (n == 0) || ($urandom_range(0, 99) == 0);
            en   = 1'($urandom_range(0, 1));
            pc   = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            cond = 1'($urandom_range(0, 1));
            bus.if_mem_ack   = ($urandom_range(0, 99) < ack_pct);
            bus.if_mem_rdata = rand_inst();
            #1;
            if (n > 0) begin
                d = m_dec ? ref_decode(m_inst, cond) : '0;
                chk1 ("rnd_mem_req", bus.if_mem_req, m_busy);
                chk32("rnd_addr",    bus.if_mem_addr, m_addr);
                chk32("rnd_inst",    inst, m_inst);
                chk1 ("rnd_valid",   iv, m_dec);
                chk1 ("rnd_branch",  br, d.br);
                chk1 ("rnd_jmp",     jmp, d.jmp);
                chk1 ("rnd_link",    lnk, d.lnk);
                chk32("rnd_offset",  off, d.off);
                chk1 ("rnd_stall",   stall, m_busy | m_dec);
                chk32("rnd_err",     32'(err), 32'(m_err));
            end
            cyc();
            if (rst) begin
                m_busy = 1'b0; m_dec = 1'b0; m_wait = 0;
                m_addr = '0;   m_inst = '0;  m_err = 2'b00;
            end else begin
                nerr = 2'b00;
                if (m_dec) begin
                    m_dec = 1'b0;
                end else if (m_busy) begin
                    if (bus.if_mem_ack) begin
                        m_inst = bus.if_mem_rdata;
                        m_busy = 1'b0;
                        m_dec  = 1'b1;
                    end else begin
                        m_wait++;
                        if (m_wait == TO) begin
                            m_busy = 1'b0;
                            nerr   = 2'b10;
                        end
                    end
                end else if (en) begin
                    if (pc % 4 != 0) begin
                        nerr = 2'b01;
                    end else begin
                        m_addr = pc;
                        m_busy = 1'b1;
                        m_wait = 0;
                    end
                end
                m_err = nerr;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum cycles spent in REQ without if_mem_ack before abort (range 1..15).
REQ-002 if_clk  input  1  single clock; all state updates on rising edge.
REQ-003 if_rst  input  1  synchronous, active-high reset, sampled on rising edge of if_clk.
REQ-004 if_en  input  1  fetch request; sampled in IDLE only.
REQ-005 if_pc_in  input  32  fetch address from the program counter.
REQ-006 if_cond  input  1  branch condition (ALU zero flag), sampled in DECODE only.
REQ-007 if_mem_req  output  1  instruction-memory read request.
REQ-008 if_mem_addr  output  32  latched fetch address, stable while if_mem_req=1.
REQ-009 if_mem_ack  input  1  memory read complete; if_mem_rdata valid in the same cycle.
REQ-010 if_mem_rdata  input  32  instruction word from memory.
REQ-011 if_inst  output  32  latched instruction word.
REQ-012 if_inst_valid  output  1  one-cycle pulse: if_inst and decode outputs valid.
REQ-013 if_branch  output  1  taken short branch, to PC branch input.
REQ-014 if_jmp  output  1  long jump, to PC jump input.
REQ-015 if_link  output  1  jump-and-link (jal) indicator.
REQ-016 if_offset_addr  output  32  unshifted offset/target field for the PC.
REQ-017 if_stall  output  1  high whenever a fetch is in flight (state REQ or DECODE).
REQ-018 if_err  output  2  one-cycle error pulse: 2'b01 misaligned, 2'b10 timeout, 2'b00 none.

Function
REQ-019 FSM states SHALL be IDLE, REQ, DECODE only.
REQ-020 IDLE: if_en=1 and if_pc_in[1:0]=2'b00 -> latch if_pc_in into if_mem_addr, clear timeout counter, go to REQ.
REQ-021 IDLE: if_en=1 and if_pc_in[1:0]!=0 -> if_err=2'b01 for one cycle, stay IDLE, no memory request.
REQ-022 REQ: if_mem_req=1; if_mem_ack=1 -> capture if_mem_rdata into if_inst, go to DECODE.
REQ-023 REQ without ack: 4-bit counter increments each cycle; when counter reaches TIMEOUT_CYCLES -> if_err=2'b10 for one cycle, if_mem_req drops, go to IDLE.
REQ-024 Ack and timeout in the same cycle: ack wins; no error.
REQ-025 DECODE: lasts exactly one cycle with if_inst_valid=1, then IDLE; if_en in DECODE is ignored.
REQ-026 Minimum latency: if_en at edge N -> if_mem_req at N+1 -> ack at N+1 -> if_inst_valid at N+2.
REQ-027 Opcode = if_inst[31:26]; decode outputs are registered from DECODE-cycle inputs and are 0 outside DECODE.
REQ-028 if_branch = (opcode 6'h04 and if_cond=1) or (opcode 6'h05 and if_cond=0).
REQ-029 if_jmp = opcode 6'h02 or 6'h03; if_link = opcode 6'h03.
REQ-030 if_offset_addr = sign-extended if_inst[15:0] for opcodes 04/05 (taken or not); {6'b0, if_inst[25:0]} for 02/03; 0 otherwise.
REQ-031 if_mem_ack outside REQ SHALL be ignored, with no state or output change.
REQ-032 if_mem_addr holds its last value outside REQ; if_inst holds until the next capture.

Reset
REQ-033 if_rst=1 at any edge -> next state IDLE; if_mem_req, if_inst_valid, if_branch, if_jmp, if_link, if_err, if_stall = 0; if_mem_addr, if_inst, if_offset_addr, counter = 0.
REQ-034 Reset during REQ aborts the fetch; a late ack after reset is ignored (REQ-031).

Verification
REQ-035 Bench: pc=0x00000010, en, ack next cycle, rdata=0x1085FFFE, cond=1 -> inst_valid at N+2, branch=1, offset=0xFFFFFFFE, jmp=0.
REQ-036 Bench: rdata=0x0C000040 (jal), ack after 3 wait cycles -> stall high 5 cycles, jmp=1, link=1, offset=0x00000040.
REQ-037 Bench: rdata=0x14A0000C (bne), cond=1 -> branch=0, offset=0x0000000C, inst_valid=1.
REQ-038 Bench: pc=0x00000006, en -> err=2'b01 for one cycle, mem_req stays 0.
REQ-039 Bench: no ack, TIMEOUT_CYCLES=15 -> err=2'b10 after 15 REQ cycles, mem_req=0 next cycle; ack exactly at cycle 15 -> no error, inst_valid.
REQ-040 Bench: rst asserted during REQ, then ack pulse -> all outputs 0, FSM IDLE, no inst_valid.
